dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single DRAM port between NUM_REQ requesters (CPU instr fetch, CPU data, video/DMA).
//  Accepts one request at a time, drives dram_addr/dram_write_en and waits a fixed DRAM_LATENCY.
//  Returns read data with a one-cycle ack to the granted requester.
//  Sits between the CPU memory-map logic / peripherals and the DRAM controller.
// PARAMETERS
//  NUM_REQ       2        number of requesters (2..8)
//  DRAM_LATENCY  10       cycles from address issue to valid dram_read_data (>=1)
//  DRAM_LAST     16'hF7FF highest word address backed by DRAM; above it is unmapped
// PORTS
//  clk              in   1                 system clock
//  rst              in   1                 reset; synchronous, active-high
//  req              in   NUM_REQ           request per requester, held until ack
//  req_addr         in   NUM_REQ*WORD_WIDTH word address per requester, slice i = requester i
//  req_we           in   NUM_REQ           write enable per requester
//  req_wdata        in   NUM_REQ*WORD_WIDTH write data per requester
//  ack              out  NUM_REQ           one-cycle completion pulse, one-hot
//  rdata            out  WORD_WIDTH        read data, valid while ack is high
//  busy             out  1                 transaction in flight (state != IDLE)
//  grant_id         out  $clog2(NUM_REQ)   index of the current/last granted requester
//  dram_addr        out  25                DRAM address, {9'b0, addr}
//  dram_write_en    out  1                 DRAM write strobe
//  dram_write_data  out  WORD_WIDTH        DRAM write data
//  dram_read_data   in   WORD_WIDTH        DRAM read data
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
//  - Reset values: ack=0, rdata=0, busy=0, grant_id=0, dram_addr=0, dram_write_en=0,
//    dram_write_data=0, state=IDLE, wait counter=0, RR pointer=NUM_REQ-1.
//  - FSM: IDLE -> ISSUE -> WAIT (DRAM_LATENCY cycles) -> DONE -> IDLE.
//    IDLE:  if any req bit is set, pick a winner, latch addr/we/wdata/grant_id, and go to ISSUE.
//           Otherwise stay in IDLE.
//    ISSUE: drive dram_addr, dram_write_en and dram_write_data; clear the counter; go to WAIT.
//    WAIT:  increment the counter; at count DRAM_LATENCY-1, go to DONE.
//    DONE:  rdata <= dram_read_data; ack[grant_id]=1 for this cycle only; dram_write_en <= 0;
//           go to IDLE.
//  - Latency: req seen in IDLE at cycle 0 -> ack at cycle DRAM_LATENCY+2 (12 with defaults).
//  - dram_write_en is held high from ISSUE through the last WAIT cycle for write transactions.
//    dram_addr is held stable until the next ISSUE.
//  - req is not sampled in ISSUE, WAIT or DONE.
//  - A requester still holding req after its ack is treated as a new request at the next IDLE.
//    Back-to-back throughput is one transaction per DRAM_LATENCY+3 cycles.
//  - Unmapped address (addr > DRAM_LAST):
//    dram_addr=0 and dram_write_en=0 throughout the transaction; the write is dropped.
//    rdata=0 at DONE. Timing is identical to a mapped access.
//  - Writes: ack is still pulsed at DONE; rdata is undefined-but-registered (value = dram_read_data).
//  - Reset in any state: return to IDLE next cycle. No ack is issued for the aborted transaction,
//    and dram_write_en drops immediately.
//  - Changes to req/addr by a requester after it is granted are ignored, because fields are latched.
// CONFIGURATION
//  DRAM_ARBITER_RR_EN defined:
//    Round-robin arbitration. The winner is the first set req strictly after the last granted
//    index, wrapping modulo NUM_REQ. The pointer updates on every grant.
//  DRAM_ARBITER_RR_EN undefined:
//    Fixed priority; the lowest index wins. Requester 0 is the CPU instruction fetch.
//    The RR pointer logic is not built.
// STRUCTURE
//  - Package dram_arb_pkg holds:
//    - state enum {IDLE, ISSUE, WAIT, DONE};
//    - DRAM_ADDR_WIDTH=25;
//    - the DRAM_ADDR_PAD function that zero-extends a word address to 25 bits.
//  - WORD_WIDTH comes from defs.vh.
//  - Sub-module arb_pick (combinational): inputs req and base pointer; outputs winner index and
//    a valid flag. Instantiated once; base is tied to NUM_REQ-1 when DRAM_ARBITER_RR_EN is off.
//  - Wait counter width is $clog2(DRAM_LATENCY+1).
// TESTING
//  1. Single read: req=2'b01, addr0=16'h0100, dram_read_data=16'hBEEF.
//     -> dram_addr=25'h0100 at cycle 1; ack=2'b01 and rdata=16'hBEEF at cycle 12; busy low at 13.
//  2. Write: req=2'b10, we1=1, addr1=16'h0042, wdata1=16'h1234.
//     -> dram_write_en high for cycles 1..11 with dram_write_data=16'h1234; ack=2'b10 at cycle 12.
//  3. Unmapped: addr0=16'hF800, we0=1 -> dram_write_en never high, dram_addr=0;
//     ack at cycle 12 with rdata=0.
//  4. Contention: req=2'b11 held continuously.
//     - RR_EN: grants alternate 0,1,0,1.
//     - Without RR_EN: grant_id stays 0 and requester 1 starves.
//  5. Reset mid-WAIT: rst=1 at cycle 5 -> cycle 6 is IDLE with busy=0 and dram_write_en=0;
//     no ack is ever issued for that transaction.
//  6. Back-to-back: req0 held high -> acks at cycles 12, 25, 38; dram_addr is re-issued each time.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// dram_arb_pkg: shared types and constants for the DRAM arbiter slice.
//   WORD_WIDTH       system word width. It matches the value the rest of the
//                    system takes from defs.vh, so this slice can build on its own.
//   DRAM_ADDR_WIDTH  width of the DRAM controller address bus.
//   state_t          arbiter FSM states.
//   DRAM_ADDR_PAD    zero-extends a word address onto the DRAM address bus.
package dram_arb_pkg;

    localparam int WORD_WIDTH      = 16;
    localparam int DRAM_ADDR_WIDTH = 25;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Word addresses occupy the low bits of the DRAM address. The upper bits
    // stay zero.
    function automatic logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_PAD(input logic [WORD_WIDTH-1:0] addr);
        return {{(DRAM_ADDR_WIDTH-WORD_WIDTH){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: requester-side bus of the DRAM arbiter.
//   req        per-requester request, held until ack
//   req_addr   packed word addresses, slice i belongs to requester i
//   req_we     per-requester write enable
//   req_wdata  packed write data, slice i belongs to requester i
//   ack        one-hot, one-cycle completion pulse
//   rdata      read data, valid while ack is high
//   busy       a transaction is in flight
//   grant_id   index of the current or last granted requester
// Modports: master = requesters, slave = arbiter.
interface dram_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    import dram_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            ack;
    logic [WORD_WIDTH-1:0]         rdata;
    logic                          busy;
    logic [IDX_W-1:0]              grant_id;

    modport master (
        output req, req_addr, req_we, req_wdata,
        input  ack, rdata, busy, grant_id
    );

    modport slave (
        input  req, req_addr, req_we, req_wdata,
        output ack, rdata, busy, grant_id
    );

endinterface

// File: rtl/dram_arbiter_pick.sv
// arb_pick: combinational winner selection for the DRAM arbiter.
//   req     request vector
//   base    index of the last grant; the search starts just after it
//   winner  first set request strictly after base, wrapping modulo NUM_REQ
//   valid   at least one request is set
// When base is NUM_REQ-1, the search starts at index 0. This gives fixed
// lowest-index priority.
module arb_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan from the farthest candidate to the nearest one. The nearest set
    // request is written last, so it wins without needing an early exit.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx    = '0;
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(base) + k) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single DRAM port among NUM_REQ requesters.
// The arbiter handles one transaction at a time:
//   IDLE -> ISSUE -> WAIT (DRAM_LATENCY cycles) -> DONE -> IDLE.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   bus              requester bus (dram_arbiter_if.slave)
//   dram_addr        DRAM address, zero-extended word address
//   dram_write_en    DRAM write strobe; held through ISSUE and WAIT for writes
//   dram_write_data  DRAM write data
//   dram_read_data   DRAM read data, valid DRAM_LATENCY cycles after ISSUE
// Macro DRAM_ARBITER_RR_EN selects round-robin arbitration. When the macro
// is not defined, the lowest index has fixed priority.
// All outputs are registered.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int                    NUM_REQ      = 2,
    parameter int                    DRAM_LATENCY = 10,
    parameter logic [WORD_WIDTH-1:0] DRAM_LAST    = 16'hF7FF
) (
    input  logic                       clk,
    input  logic                       rst,
    dram_arbiter_if.slave              bus,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    output logic                       dram_write_en,
    output logic [WORD_WIDTH-1:0]      dram_write_data,
    input  logic [WORD_WIDTH-1:0]      dram_read_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DRAM_LATENCY + 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      count;
    logic                  wait_done;

    logic [IDX_W-1:0]      base, winner;
    logic                  win_valid;
    logic [WORD_WIDTH-1:0] win_addr, win_wdata;
    logic                  win_we, win_mapped;

    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic                  unmapped_q, unmapped_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr_d;
    logic                  we_d;
    logic [WORD_WIDTH-1:0] wdata_d;

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .base   (base),
        .winner (winner),
        .valid  (win_valid)
    );

`ifdef DRAM_ARBITER_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // The round-robin pointer records the last winner. The next search
    // therefore starts just past that requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (state == IDLE && win_valid) begin
            rr_ptr <= winner;
        end
    end

    assign base = rr_ptr;
`else
    assign base = IDX_W'(NUM_REQ - 1);
`endif

    assign win_addr   = bus.req_addr[winner*WORD_WIDTH +: WORD_WIDTH];
    assign win_wdata  = bus.req_wdata[winner*WORD_WIDTH +: WORD_WIDTH];
    assign win_we     = bus.req_we[winner];
    assign win_mapped = (win_addr <= DRAM_LAST);
    assign wait_done  = (state == WAIT) && (count == CNT_W'(DRAM_LATENCY - 1));

    // State register and wait counter. ISSUE clears the counter, so count
    // runs from 0 to DRAM_LATENCY-1 across the WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == ISSUE) begin
                count <= '0;
            end else if (state == WAIT) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Next-state logic. Requests are only looked at while IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output next-values. The DRAM-side signals load on the edge into ISSUE,
    // so they are valid during ISSUE. Ack, rdata and the drop of the write
    // strobe load on the edge into DONE.
    // Unmapped accesses never reach the DRAM: address 0, no strobe, rdata 0.
    always_comb begin
        ack_d      = '0;
        rdata_d    = rdata_q;
        busy_d     = (state_next != IDLE);
        grant_d    = grant_q;
        unmapped_d = unmapped_q;
        addr_d     = dram_addr;
        we_d       = dram_write_en;
        wdata_d    = dram_write_data;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_d    = winner;
                    unmapped_d = !win_mapped;
                    addr_d     = win_mapped ? DRAM_ADDR_PAD(win_addr) : '0;
                    we_d       = win_we && win_mapped;
                    wdata_d    = win_wdata;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    we_d    = 1'b0;
                    ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                    rdata_d = unmapped_q ? '0 : dram_read_data;
                end
            end
            default: ;
        endcase
    end

    // Output registers. A reset aborts any transaction. No ack is issued for
    // the aborted transaction, and the write strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q           <= '0;
            rdata_q         <= '0;
            busy_q          <= 1'b0;
            grant_q         <= '0;
            unmapped_q      <= 1'b0;
            dram_addr       <= '0;
            dram_write_en   <= 1'b0;
            dram_write_data <= '0;
        end else begin
            ack_q           <= ack_d;
            rdata_q         <= rdata_d;
            busy_q          <= busy_d;
            grant_q         <= grant_d;
            unmapped_q      <= unmapped_d;
            dram_addr       <= addr_d;
            dram_write_en   <= we_d;
            dram_write_data <= wdata_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter using the default
// parameters. Each expected ack and its read data are queued when a request
// is driven. They are checked when the arbiter pulses ack. Cycle-accurate
// checks cover the DRAM-side signals.
// Honours DRAM_ARBITER_RR_EN for the expected contention order.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int NREQ = 2;

    typedef struct {
        int                    id;
        logic [WORD_WIDTH-1:0] rdata;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
    logic                       dram_write_en;
    logic [WORD_WIDTH-1:0]      dram_write_data;
    logic [WORD_WIDTH-1:0]      dram_read_data;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    bit   mon_en = 1'b0;
    int   acks;

    dram_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    dram_arbiter #(
        .NUM_REQ      (NREQ),
        .DRAM_LATENCY (10),
        .DRAM_LAST    (16'hF7FF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .dram_addr       (dram_addr),
        .dram_write_en   (dram_write_en),
        .dram_write_data (dram_write_data),
        .dram_read_data  (dram_read_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive one requester and queue n expected completions for it.
    task automatic applyStimulus(input int id, input logic [WORD_WIDTH-1:0] addr, input logic we,
                                 input logic [WORD_WIDTH-1:0] wdata, input logic [WORD_WIDTH-1:0] exp_rdata,
                                 input int n);
        exp_t e;
        bus.req_addr[id*WORD_WIDTH +: WORD_WIDTH]  = addr;
        bus.req_wdata[id*WORD_WIDTH +: WORD_WIDTH] = wdata;
        bus.req_we[id] = we;
        bus.req[id]    = 1'b1;
        e.id    = id;
        e.rdata = exp_rdata;
        repeat (n) sb.push_back(e);
    endtask

    // Scoreboard side: every ack pulse must match the oldest queued completion.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && bus.ack != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", 32'(bus.ack), 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_ack", 32'(bus.ack), 32'(1 << e.id));
                checkOutput("sb_rdata", 32'(bus.rdata), 32'(e.rdata));
            end
        end
    end

    initial begin
        bus.req        = '0;
        bus.req_addr   = '0;
        bus.req_we     = '0;
        bus.req_wdata  = '0;
        dram_read_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ack", 32'(bus.ack), 32'h0);
        checkOutput("rst_rdata", 32'(bus.rdata), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_grant", 32'(bus.grant_id), 32'h0);
        checkOutput("rst_addr", 32'(dram_addr), 32'h0);
        checkOutput("rst_wen", 32'(dram_write_en), 32'h0);
        checkOutput("rst_wdata", 32'(dram_write_data), 32'h0);
        mon_en = 1'b1;

        // Single read
        @(posedge clk);
        #1;
        dram_read_data = 16'hBEEF;
        applyStimulus(0, 16'h0100, 1'b0, 16'h0000, 16'hBEEF, 1);
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("t1_addr", 32'(dram_addr), 32'h0100);
                checkOutput("t1_busy", 32'(bus.busy), 32'h1);
                checkOutput("t1_grant", 32'(bus.grant_id), 32'h0);
            end
            if (c == 11) checkOutput("t1_ack_early", 32'(bus.ack), 32'h0);
            if (c == 12) begin
                checkOutput("t1_ack", 32'(bus.ack), 32'h1);
                checkOutput("t1_rdata", 32'(bus.rdata), 32'hBEEF);
                bus.req[0] = 1'b0;
            end
            if (c == 13) checkOutput("t1_busy_end", 32'(bus.busy), 32'h0);
        end

        // Write from requester 1
        @(posedge clk);
        #1;
        dram_read_data = 16'h5A5A;
        applyStimulus(1, 16'h0042, 1'b1, 16'h1234, 16'h5A5A, 1);
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            checkOutput("t2_wen", 32'(dram_write_en), (c >= 1 && c <= 11) ? 32'h1 : 32'h0);
            if (c == 1) begin
                checkOutput("t2_wdata", 32'(dram_write_data), 32'h1234);
                checkOutput("t2_addr", 32'(dram_addr), 32'h0042);
                checkOutput("t2_grant", 32'(bus.grant_id), 32'h1);
            end
            if (c == 12) begin
                checkOutput("t2_ack", 32'(bus.ack), 32'h2);
                bus.req[1]    = 1'b0;
                bus.req_we[1] = 1'b0;
            end
        end

        // Unmapped write: never reaches DRAM, rdata is zero
        @(posedge clk);
        #1;
        dram_read_data = 16'h1111;
        applyStimulus(0, 16'hF800, 1'b1, 16'hFFFF, 16'h0000, 1);
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            checkOutput("t3_wen", 32'(dram_write_en), 32'h0);
            if (c >= 1 && c <= 11) checkOutput("t3_addr", 32'(dram_addr), 32'h0);
            if (c == 12) begin
                checkOutput("t3_ack", 32'(bus.ack), 32'h1);
                checkOutput("t3_rdata", 32'(bus.rdata), 32'h0);
                bus.req[0]    = 1'b0;
                bus.req_we[0] = 1'b0;
            end
        end

        // Contention: both requesters held; reset first to restore the pointer
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        dram_read_data = 16'h7777;
        applyStimulus(0, 16'h0010, 1'b0, 16'h0000, 16'h7777, 0);
        applyStimulus(1, 16'h0020, 1'b0, 16'h0000, 16'h7777, 0);
`ifdef DRAM_ARBITER_RR_EN
        sb.push_back('{0, 16'h7777});
        sb.push_back('{1, 16'h7777});
        sb.push_back('{0, 16'h7777});
        sb.push_back('{1, 16'h7777});
`else
        repeat (4) sb.push_back('{0, 16'h7777});
`endif
        acks = 0;
        for (int c = 0; c < 80 && acks < 4; c++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                acks++;
                if (acks == 4) bus.req = '0;
            end
        end
        bus.req = '0;
        checkOutput("t4_acks", 32'(acks), 32'd4);

        // Reset during WAIT aborts without an ack
        @(posedge clk);
        #1;
        dram_read_data = 16'h0000;
        applyStimulus(0, 16'h0200, 1'b1, 16'hABCD, 16'h0000, 0);
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checkOutput("t5_wen_pre", 32'(dram_write_en), 32'h1);
                rst        = 1'b1;
                bus.req    = '0;
                bus.req_we = '0;
            end
            if (c == 6) begin
                checkOutput("t5_busy", 32'(bus.busy), 32'h0);
                checkOutput("t5_wen", 32'(dram_write_en), 32'h0);
                rst = 1'b0;
            end
            if (c == 12) checkOutput("t5_no_ack", 32'(bus.ack), 32'h0);
        end

        // Back-to-back: requester 0 held across three transactions
        @(posedge clk);
        #1;
        dram_read_data = 16'hCAFE;
        applyStimulus(0, 16'h0300, 1'b0, 16'h0000, 16'hCAFE, 3);
        for (int c = 0; c <= 39; c++) begin
            @(negedge clk);
            if (c == 12 || c == 25 || c == 38) checkOutput("t6_ack", 32'(bus.ack), 32'h1);
            if (c == 11 || c == 24 || c == 37) checkOutput("t6_ack_early", 32'(bus.ack), 32'h0);
            if (c == 13 || c == 26) checkOutput("t6_busy_gap", 32'(bus.busy), 32'h0);
            if (c == 1 || c == 14 || c == 27) begin
                checkOutput("t6_addr", 32'(dram_addr), 32'h0300);
                checkOutput("t6_busy", 32'(bus.busy), 32'h1);
            end
            if (c == 38) bus.req[0] = 1'b0;
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
